param_countdown_timer: RTL and testbench



---
 rtl/param_countdown_timer_pkg.sv | 22 ++
 rtl/param_countdown_timer_tick_prescaler.sv | 27 ++
 rtl/param_countdown_timer.sv | 137 +++++++++++++
 tb/tb_param_countdown_timer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/param_countdown_timer_pkg.sv
// Shared types and constants for the countdown timer family.
// Includes the saturating two-digit decimal helper used by the optional BCD outputs.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_PRESCALE = 100_000_000;
  localparam int DEFAULT_LOAD     = 5;

  // Tens/ones digits of v; anything above 99 pins to 9,9.
  function automatic logic [7:0] bcd_sat99(input logic [31:0] v);
    logic [31:0] s;
    s = (v > 32'd99) ? 32'd99 : v;
    return {4'(s / 32'd10), 4'(s % 32'd10)};
  endfunction

endpackage

// File: rtl/param_countdown_timer_tick_prescaler.sv
// Free-running modulo-PRESCALE counter with enable and synchronous clear.
// tick is combinational: high on the last phase of a period while enabled.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0]  LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // clr beats en so a restart always begins a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tick ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/param_countdown_timer.sv
// Prescaled loadable down-counter with start/pause/resume and one-shot or auto-reload.
// Optional COUNTDOWN_BCD_EN adds registered decimal digit outputs bcd_tens/bcd_ones.
module param_countdown_timer #(
  parameter int CNT_W        = 8,
  parameter int PRESCALE     = countdown_pkg::DEFAULT_PRESCALE,
  parameter int DEFAULT_LOAD = countdown_pkg::DEFAULT_LOAD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             step_tick,
  output logic             expired
`ifdef COUNTDOWN_BCD_EN
  ,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
`endif
);

  import countdown_pkg::*;

  localparam logic [1:0]       S_IDLE   = 2'(IDLE);
  localparam logic [1:0]       S_RUN    = 2'(RUN);
  localparam logic [1:0]       S_PAUSED = 2'(PAUSED);
  localparam logic [1:0]       S_DONE   = 2'(DONE);
  localparam logic [CNT_W-1:0] LOAD_RST = CNT_W'(DEFAULT_LOAD);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] reload, reload_nxt;
  logic             step_nxt, exp_nxt;
  logic             pre_en, pre_clr, tick;

  // Prescaler only advances in RUN with no higher-priority control this cycle.
  assign pre_en = (state == S_RUN) && !load && !pause;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_pre (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    step_nxt   = 1'b0;
    exp_nxt    = 1'b0;
    pre_clr    = 1'b0;
    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      pre_clr    = 1'b1;
      state_nxt  = S_IDLE;
    end else if (pause && state == S_RUN) begin
      state_nxt = S_PAUSED;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && count != '0) begin
            pre_clr   = 1'b1;
            state_nxt = S_RUN;
          end
        end
        S_PAUSED: begin
          if (start) state_nxt = S_RUN;
        end
        S_DONE: begin
          if (start && reload != '0) begin
            count_nxt = reload;
            pre_clr   = 1'b1;
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (tick) begin
            step_nxt = 1'b1;
            if (count > CNT_W'(1)) begin
              count_nxt = count - CNT_W'(1);
            end else begin
              // Final step of the period; auto_reload is only looked at here.
              exp_nxt = 1'b1;
              if (auto_reload) begin
                count_nxt = reload;
              end else begin
                count_nxt = '0;
                state_nxt = S_DONE;
              end
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= LOAD_RST;
      reload    <= LOAD_RST;
      running   <= 1'b0;
      step_tick <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      reload    <= reload_nxt;
      running   <= (state_nxt == S_RUN);
      step_tick <= step_nxt;
      expired   <= exp_nxt;
    end
  end

`ifdef COUNTDOWN_BCD_EN
  localparam logic [7:0] BCD_RST = bcd_sat99(32'(DEFAULT_LOAD));

  // Digits trail count by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {bcd_tens, bcd_ones} <= BCD_RST;
    else       {bcd_tens, bcd_ones} <= bcd_sat99(32'(count));
  end
`else
  // Digit outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_param_countdown_timer.sv
// Directed and randomized bench for param_countdown_timer (PRESCALE=4, CNT_W=8).
// A rule-level reference model predicts every output cycle by cycle.
module tb_param_countdown_timer;

  localparam int P  = 4;
  localparam int W  = 8;
  localparam int DL = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic         clk = 1'b0, reset = 1'b1;
  logic         load = 1'b0, start = 1'b0, pause = 1'b0, auto_reload = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         running, step_tick, expired;
`ifdef COUNTDOWN_BCD_EN
  logic [3:0]   bcd_tens, bcd_ones;
`endif

  int checks = 0, errors = 0;
  int ncyc = 0, last_step = -1, last_exp = -1, exp_total = 0;
  bit saw_zero = 0;
  int m_st, m_cnt, m_rel, m_ph, m_bcd;
  bit m_step, m_exp;

  param_countdown_timer #(.CNT_W(W), .PRESCALE(P), .DEFAULT_LOAD(DL)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .count       (count),
    .running     (running),
    .step_tick   (step_tick),
    .expired     (expired)
`ifdef COUNTDOWN_BCD_EN
    ,
    .bcd_tens    (bcd_tens),
    .bcd_ones    (bcd_ones)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int bcd_of(input int v);
    int s;
    s = (v > 99) ? 99 : v;
    return (s / 10) * 16 + (s % 10);
  endfunction

  task automatic model_reset;
    m_st = M_IDLE; m_cnt = DL; m_rel = DL; m_ph = 0;
    m_step = 0; m_exp = 0; m_bcd = bcd_of(DL);
  endtask

  // One clock edge of the timer, written from the behavioural rules.
  task automatic model_edge(input bit l, input int lv, input bit s, input bit p, input bit ar);
    m_bcd = bcd_of(m_cnt);
    m_step = 0; m_exp = 0;
    if (l) begin
      m_cnt = lv; m_rel = lv; m_ph = 0; m_st = M_IDLE;
    end else if (p && m_st == M_RUN) begin
      m_st = M_PAUSED;
    end else if (s && m_st == M_IDLE && m_cnt != 0) begin
      m_ph = 0; m_st = M_RUN;
    end else if (s && m_st == M_PAUSED) begin
      m_st = M_RUN;
    end else if (s && m_st == M_DONE && m_rel != 0) begin
      m_cnt = m_rel; m_ph = 0; m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (m_ph == P - 1) begin
        m_ph = 0; m_step = 1;
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else begin
          m_exp = 1;
          if (ar) m_cnt = m_rel;
          else begin m_cnt = 0; m_st = M_DONE; end
        end
      end else m_ph = m_ph + 1;
    end
  endtask

  task automatic cmp_all;
    chk("count", 32'(count), 32'(m_cnt));
    chk("running", 32'(running), 32'(m_st == M_RUN));
    chk("step_tick", 32'(step_tick), 32'(m_step));
    chk("expired", 32'(expired), 32'(m_exp));
`ifdef COUNTDOWN_BCD_EN
    chk("bcd", 32'({bcd_tens, bcd_ones}), 32'(m_bcd));
`endif
  endtask

  task automatic cyc(input bit l, input int lv, input bit s, input bit p, input bit ar);
    load = l; load_val = W'(lv); start = s; pause = p; auto_reload = ar;
    @(posedge clk);
    ncyc++;
    model_edge(l, lv, s, p, ar);
    #1;
    cmp_all();
    if (step_tick) last_step = ncyc;
    if (expired) begin last_exp = ncyc; exp_total++; end
    if (count == '0) saw_zero = 1;
    load = 0; start = 0; pause = 0;
  endtask

  task automatic idle(input int n, input bit ar);
    repeat (n) cyc(0, 0, 0, 0, ar);
  endtask

  initial begin
    int ns, e0;
    bit ar;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    chk("rst_count", 32'(count), 32'd5);
    reset = 0;

    // One-shot from default load: 5 steps of 4 cycles.
    cyc(0, 0, 1, 0, 0); ns = ncyc;
    idle(22, 0);
    chk("t1_exp_delay", 32'(last_exp - ns), 32'd20);
    chk("t1_exp_total", 32'(exp_total), 32'd1);
    chk("t1_running", 32'(running), 32'd0);
    chk("t1_count", 32'(count), 32'd0);

    // Auto-reload from 3: expired every 12 cycles, never reads 0.
    cyc(1, 3, 0, 0, 1);
    cyc(0, 0, 1, 0, 1); ns = ncyc; saw_zero = 0; e0 = exp_total;
    idle(36, 1);
    chk("t2_exp_count", 32'(exp_total - e0), 32'd3);
    chk("t2_last_exp", 32'(last_exp - ns), 32'd36);
    chk("t2_no_zero", 32'(saw_zero), 32'd0);
    chk("t2_running", 32'(running), 32'd1);

    // Pause mid-period, resume 9 cycles later: period stretched by 10.
    cyc(1, 5, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); ns = ncyc;
    idle(6, 0);
    cyc(0, 0, 0, 1, 0);
    idle(8, 0);
    chk("t3_frozen", 32'(last_step - ns), 32'd4);
    chk("t3_paused_cnt", 32'(count), 32'd4);
    cyc(0, 0, 1, 0, 0);
    idle(2, 0);
    chk("t3_resume_step", 32'(last_step - ns), 32'd18);
    idle(12, 0);
    chk("t3_exp_delay", 32'(last_exp - ns), 32'd30);

    // load + start together while running: load wins.
    cyc(1, 9, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(5, 0);
    cyc(1, 7, 1, 0, 0);
    chk("t4_running", 32'(running), 32'd0);
    chk("t4_count", 32'(count), 32'd7);
    cyc(0, 0, 1, 0, 0); ns = ncyc;
    idle(4, 0);
    chk("t4_first_step", 32'(last_step - ns), 32'd4);
    chk("t4_count_after", 32'(count), 32'd6);

    // load 0 then start: no run, no expiry.
    cyc(1, 0, 0, 0, 0); e0 = exp_total;
    cyc(0, 0, 1, 0, 0);
    idle(6, 0);
    chk("t5_running", 32'(running), 32'd0);
    chk("t5_no_exp", 32'(exp_total - e0), 32'd0);

    // Reset asserted mid-run.
    cyc(1, 9, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(5, 0);
    reset = 1;
    #1;
    model_reset();
    chk("t6_count", 32'(count), 32'd5);
    chk("t6_running", 32'(running), 32'd0);
    chk("t6_step", 32'(step_tick), 32'd0);
    chk("t6_exp", 32'(expired), 32'd0);
    @(posedge clk); #1;
    cmp_all();
    reset = 0;

`ifdef COUNTDOWN_BCD_EN
    cyc(1, 123, 0, 0, 0);
    idle(1, 0);
    chk("bcd_sat", 32'({bcd_tens, bcd_ones}), 32'h99);
    cyc(1, 42, 0, 0, 0);
    chk("bcd_lag", 32'({bcd_tens, bcd_ones}), 32'h99);
    idle(1, 0);
    chk("bcd_42", 32'({bcd_tens, bcd_ones}), 32'h42);
`endif

    // Randomized control traffic against the model.
    ar = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) ar = ~ar;
      cyc($urandom_range(0, 29) == 0, int'($urandom_range(0, 6)),
          $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, ar);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
